// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Watches a multiplexed seven-segment bus and recovers the hex value shown
//   on each digit. Every digit is filtered for stability, decoded back to a
//   nibble, and gathered into a frame. Frames are offered on a valid/ready
//   interface.
//
//   Optional feature: define SEG_SCAN_READER_DP_EN to also recover the
//   decimal point of each digit (ports seg_dp / frame_dp).
//
// Parameters
//   DIGITS      number of multiplexed digits (1..8)
//   STABLE_CYC  consecutive identical samples required before capture (2..255)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   seg          segment pattern {a,b,c,d,e,f,g}, 1 = lit
//   sel_n        active-low digit select, bit i = digit i
//   seg_dp       decimal point input (SEG_SCAN_READER_DP_EN only)
//   frame_data   decoded nibbles, digit i at [4i+3:4i]
//   frame_err    bit i set = digit i pattern was not a legal code
//   frame_dp     captured decimal points (SEG_SCAN_READER_DP_EN only)
//   frame_valid  a frame is being presented
//   frame_ready  consumer accepts the presented frame
//   overrun      one-cycle pulse when a completed frame had to be dropped
module seg_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     sel_n,
`ifdef SEG_SCAN_READER_DP_EN
    input  logic                  seg_dp,
    output logic [DIGITS-1:0]     frame_dp,
`endif
    output logic [4*DIGITS-1:0]   frame_data,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

`ifdef SEG_SCAN_READER_DP_EN
    localparam int DP_W = 1;
`else
    localparam int DP_W = 0;
`endif
    localparam int SW = DIGITS + 7 + DP_W;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Reset sample looks like a blanked display: no digit selected, no segment lit.
    localparam logic [SW-1:0] SAMP_RST = {{DIGITS{1'b1}}, {(SW - DIGITS){1'b0}}};

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Exactly one digit selected (one bit low).
    function automatic logic one_low(input logic [DIGITS-1:0] s);
        return ($countones(~s) == 1);
    endfunction

    // Position of the low bit; only meaningful when one_low() is true.
    function automatic logic [IW-1:0] low_idx(input logic [DIGITS-1:0] s);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    logic [SW-1:0]       in_vec;
    logic [SW-1:0]       samp;
    logic [CW-1:0]       cnt;
    logic                stable;
    logic                cap_ok;
    logic [IW-1:0]       cap_idx;
    logic [4:0]          dec;
    logic [DIGITS-1:0]   samp_sel;
    logic [6:0]          samp_seg;

    logic [4*DIGITS-1:0] slot_data, slot_data_nx;
    logic [DIGITS-1:0]   slot_err, slot_err_nx;
    logic [DIGITS-1:0]   seen, seen_nx;
    logic                complete;

    state_t              state, state_nx;
    logic                load;
    logic                drop;

`ifdef SEG_SCAN_READER_DP_EN
    logic [DIGITS-1:0]   slot_dp, slot_dp_nx;
    assign in_vec = {sel_n, seg, seg_dp};
`else
    assign in_vec = {sel_n, seg};
`endif

    assign samp_sel = samp[SW-1 -: DIGITS];
    assign samp_seg = samp[6+DP_W -: 7];

    // Capture fires only on the step from STABLE_CYC-1 to STABLE_CYC, so a
    // window that stays stable longer (counter saturated) captures once.
    assign stable  = (in_vec == samp);
    assign cap_ok  = stable && (cnt == CW'(STABLE_CYC - 1)) && one_low(samp_sel);
    assign cap_idx = low_idx(samp_sel);
    assign dec     = decode(samp_seg);

    // Slot update for this cycle's capture; the frame copy must include the
    // digit captured on the completing edge, so it reads these next values.
    always_comb begin
        slot_data_nx = slot_data;
        slot_err_nx  = slot_err;
        seen_nx      = seen;
`ifdef SEG_SCAN_READER_DP_EN
        slot_dp_nx   = slot_dp;
`endif
        if (cap_ok) begin
            slot_data_nx[4*int'(cap_idx) +: 4] = dec[3:0];
            slot_err_nx[cap_idx]               = dec[4];
            seen_nx[cap_idx]                   = 1'b1;
`ifdef SEG_SCAN_READER_DP_EN
            slot_dp_nx[cap_idx]                = samp[0];
`endif
        end
    end

    assign complete = &seen_nx;

    // Output-side FSM
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        drop     = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    load     = 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                // A frame completing while the old one is being accepted
                // replaces it directly; without acceptance it is dropped.
                if (complete) begin
                    if (frame_ready) load = 1'b1;
                    else             drop = 1'b1;
                end else if (frame_ready) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    assign frame_valid = (state == PRESENT);

    // Sampling, stability filter, slots and frame registers
    always_ff @(posedge clk) begin
        if (rst) begin
            samp       <= SAMP_RST;
            cnt        <= '0;
            seen       <= '0;
            slot_data  <= '0;
            slot_err   <= '0;
            frame_data <= '0;
            frame_err  <= '0;
            overrun    <= 1'b0;
`ifdef SEG_SCAN_READER_DP_EN
            slot_dp    <= '0;
            frame_dp   <= '0;
`endif
        end else begin
            samp <= in_vec;
            if (!stable) begin
                cnt <= '0;
            end else if (cnt != CW'(STABLE_CYC)) begin
                cnt <= cnt + 1'b1;
            end
            slot_data <= slot_data_nx;
            slot_err  <= slot_err_nx;
            seen      <= complete ? '0 : seen_nx;
            if (load) begin
                frame_data <= slot_data_nx;
                frame_err  <= slot_err_nx;
            end
            overrun <= drop;
`ifdef SEG_SCAN_READER_DP_EN
            slot_dp <= slot_dp_nx;
            if (load) frame_dp <= slot_dp_nx;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Testbench for seg_scan_reader (DIGITS=4, STABLE_CYC=4): directed scans
// followed by randomized segment bursts checked against a segment-level model.
module tb_seg_scan_reader;

    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  sel_n;
    logic [15:0] frame_data;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;
`ifdef SEG_SCAN_READER_DP_EN
    logic        seg_dp;
    logic [3:0]  frame_dp;
    logic        dp_now = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;

    logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .sel_n       (sel_n),
`ifdef SEG_SCAN_READER_DP_EN
        .seg_dp      (seg_dp),
        .frame_dp    (frame_dp),
`endif
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // overrun is a full-cycle pulse, so each pulse is seen on exactly one falling edge
    always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
        sel_n = s;
        seg   = g;
`ifdef SEG_SCAN_READER_DP_EN
        seg_dp = dp_now;
`endif
        step(n);
    endtask

    function automatic logic [3:0] dsel(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    // Scan all four digits, 8 cycles each; vals nibble i shown on digit i.
    task automatic scan(input logic [15:0] vals);
        for (int i = 0; i < 4; i++) drive(dsel(i), pat[vals[4*i +: 4]], 8);
    endtask

    task automatic consume();
        frame_ready = 1'b1;
        step(1);
        frame_ready = 1'b0;
    endtask

    // Segment-level reference model
    logic [3:0]  m_nib [4];
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  m_ferr;
    int          m_ovr;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_err = '0; m_seen = '0; m_valid = 1'b0; m_data = '0; m_ferr = '0; m_ovr = 0;
    endtask

    // One maximal run of a constant bus value lasting len cycles (ready held low).
    task automatic model_seg(input logic [3:0] s, input logic [6:0] g, input int len);
        int   idx;
        logic found;
        logic [3:0] nib;
        if (len >= S + 1 && $countones(~s) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!s[i]) idx = i;
            found = 1'b0;
            nib   = 4'h0;
            for (int v = 0; v < 16; v++) if (pat[v] == g) begin nib = 4'(v); found = 1'b1; end
            m_nib[idx]  = nib;
            m_err[idx]  = !found;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_seen = '0;
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_data  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    m_ferr  = m_err;
                end else begin
                    m_ovr++;
                end
            end
        end
    endtask

    initial begin
        int         ovr0;
        logic [3:0] s;
        logic [6:0] g;
        logic [10:0] prev;
        int         len;
        int         r;

        rst = 1'b1; frame_ready = 1'b0;
        drive(4'hF, 7'h00, 3);
        rst = 1'b0;
        check("reset_valid", frame_valid, 1'b0);
        check("reset_data", frame_data, 16'h0);
        check("reset_err", frame_err, 4'h0);
        check("reset_ovr", overrun, 1'b0);

        // Basic scan with exact latency of the last capture
        for (int i = 0; i < 3; i++) drive(dsel(i), pat[i+1], 8);
        drive(dsel(3), pat[4], S);
        check("latency_early", frame_valid, 1'b0);
        step(1);
        check("latency_valid", frame_valid, 1'b1);
        check("scan_data", frame_data, 16'h4321);
        check("scan_err", frame_err, 4'h0);
        step(3);
        check("hold_valid", frame_valid, 1'b1);
        consume();
        check("consume_valid", frame_valid, 1'b0);

        // One-cycle glitch inside digit 1's window
        drive(dsel(0), pat[5], 8);
        drive(dsel(1), pat[6], 2);
        drive(dsel(1), 7'h00, 1);
        drive(dsel(1), pat[6], 6);
        drive(dsel(2), pat[7], 8);
        drive(dsel(3), pat[8], 8);
        check("glitch_valid", frame_valid, 1'b1);
        check("glitch_data", frame_data, 16'h8765);
        check("glitch_err", frame_err, 4'h0);
        consume();

        // Hold of exactly STABLE_CYC is too short; STABLE_CYC+1 is enough
        for (int i = 1; i < 4; i++) drive(dsel(i), pat[i], 8);
        drive(dsel(0), pat[9], S);
        drive(4'hF, 7'h00, 3);
        check("short_hold_valid", frame_valid, 1'b0);
        drive(dsel(0), pat[10], S + 1);
        check("min_hold_valid", frame_valid, 1'b1);
        check("min_hold_data", frame_data, 16'h321A);
        consume();

        // Illegal pattern on digit 2
        drive(dsel(0), pat[7], 8);
        drive(dsel(1), pat[9], 8);
        drive(dsel(2), 7'b1010101, 8);
        drive(dsel(3), pat[12], 8);
        check("bad_valid", frame_valid, 1'b1);
        check("bad_data", frame_data, 16'hC097);
        check("bad_err", frame_err, 4'b0100);
        consume();

        // Overrun, then a frame completing during acceptance
        ovr0 = ovr_cnt;
        scan(16'hBCDE);
        check("ovr_first_valid", frame_valid, 1'b1);
        scan(16'h3210);
        check("ovr_held_valid", frame_valid, 1'b1);
        check("ovr_held_data", frame_data, 16'hBCDE);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        for (int i = 0; i < 3; i++) drive(dsel(i), pat[i+5], 8);
        drive(dsel(3), pat[9], S);
        frame_ready = 1'b1;
        step(1);
        frame_ready = 1'b0;
        check("swap_valid", frame_valid, 1'b1);
        check("swap_data", frame_data, 16'h9765);
        step(2);
        check("swap_no_ovr", ovr_cnt - ovr0, 1);
        consume();
        check("swap_consumed", frame_valid, 1'b0);

        // Blank and multi-select are never captured; reset clears partial frame
        drive(4'hF, pat[8], 20);
        drive(4'b1100, pat[8], 20);
        for (int i = 1; i < 4; i++) drive(dsel(i), pat[i], 8);
        check("nosel_valid", frame_valid, 1'b0);
        rst = 1'b1;
        drive(4'hF, 7'h00, 1);
        rst = 1'b0;
        check("midrst_valid", frame_valid, 1'b0);
        check("midrst_data", frame_data, 16'h0);
        check("midrst_err", frame_err, 4'h0);
        drive(dsel(0), pat[4], 8);
        check("midrst_partial", frame_valid, 1'b0);
        scan(16'hDCBA);
        check("postrst_valid", frame_valid, 1'b1);
        check("postrst_data", frame_data, 16'hDCBA);
        consume();

`ifdef SEG_SCAN_READER_DP_EN
        dp_now = 1'b1;
        drive(dsel(0), pat[1], 8);
        dp_now = 1'b0;
        for (int i = 1; i < 4; i++) drive(dsel(i), pat[i+1], 8);
        check("dp_bits", frame_dp, 4'b0001);
        check("dp_data", frame_data, 16'h4321);
        consume();
`endif

        // Randomized bursts against the segment-level model
        rst = 1'b1;
        drive(4'hF, 7'h00, 1);
        rst = 1'b0;
        model_reset();
        for (int b = 0; b < 10; b++) begin
            ovr0 = ovr_cnt;
            prev = {4'hF, 7'h00};
            for (int k = 0; k < 30; k++) begin
                do begin
                    r = $urandom_range(0, 9);
                    if (r < 7)       s = dsel($urandom_range(0, 3));
                    else if (r == 7) s = 4'hF;
                    else             s = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 9) < 7) g = pat[$urandom_range(0, 15)];
                    else                          g = 7'($urandom_range(0, 127));
                end while ({s, g} == prev);
                len = $urandom_range(1, 10);
                drive(s, g, len);
                prev = {s, g};
                model_seg(s, g, len);
            end
            drive(4'hF, 7'h00, 3);
            check("rnd_valid", frame_valid, m_valid);
            check("rnd_ovr", ovr_cnt - ovr0, m_ovr);
            m_ovr = 0;
            if (m_valid) begin
                check("rnd_data", frame_data, m_data);
                check("rnd_err", frame_err, m_ferr);
                consume();
                m_valid = 1'b0;
                check("rnd_consumed", frame_valid, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
